// File: rtl/lcd_4bit_driver.sv
// HD44780 16x2 character LCD controller on a 4-bit write-only bus: power-on init, then endless refresh.
// Build option LCD_FRAME_LATCH_EN snapshots both rows once per frame so a frame never mixes old and new text.
module lcd_4bit_driver #(
    parameter int PWRUP_CYC      = 1_500_000,
    parameter int INIT_WAIT_CYC  = 410_000,
    parameter int CMD_WAIT_CYC   = 4_000,
    parameter int CLEAR_WAIT_CYC = 200_000,
    parameter int SETUP_CYC      = 4,
    parameter int E_PULSE_CYC    = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] row_A,
    input  logic [127:0] row_B,
    output logic         LCD_E,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic [3:0]   LCD_D,
    output logic         init_done,
    output logic         frame_done
);
    localparam int MAX_0   = (PWRUP_CYC > INIT_WAIT_CYC) ? PWRUP_CYC : INIT_WAIT_CYC;
    localparam int MAX_1   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_2   = (SETUP_CYC > E_PULSE_CYC) ? SETUP_CYC : E_PULSE_CYC;
    localparam int MAX_3   = (MAX_0 > MAX_1) ? MAX_0 : MAX_1;
    localparam int MAX_4   = (MAX_3 > MAX_2) ? MAX_3 : MAX_2;
    localparam int MAX_CYC = (MAX_4 > 2) ? MAX_4 : 2;
    localparam int CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] IWAIT_LAST = CNT_W'(INIT_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_PULSE_CYC - 1);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT_NIB, S_INIT_CMD, S_ADDR_A, S_CHARS_A, S_ADDR_B, S_CHARS_B
    } seq_e;
    typedef enum logic [1:0] {P_SETUP, P_EHI, P_EHOLD, P_WAIT} phase_e;

    seq_e             seq_q, seq_d, adv_seq;
    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, wait_last;
    logic [3:0]       step_q, step_d, adv_step;
    logic [3:0]       char_q, char_d, adv_char;
    logic [7:0]       byte_q, byte_d, item_byte;
    logic             rs_q, rs_d, item_rs;
    logic             nib_lo_q, nib_lo_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;
    logic             load;
    logic [127:0]     src_a, src_b;
    logic [7:0]       chars_a [16];
    logic [7:0]       chars_b [16];

`ifdef LCD_FRAME_LATCH_EN
    logic [255:0] shadow_q;

    // Snapshot taken on the same edge that starts the 0x80 address byte.
    always_ff @(posedge clk) begin
        if (reset)
            shadow_q <= '0;
        else if (load && adv_seq == S_ADDR_A)
            shadow_q <= {row_A, row_B};
    end

    assign src_a = shadow_q[255:128];
    assign src_b = shadow_q[127:0];
`else
    assign src_a = row_A;
    assign src_b = row_B;
`endif

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_chars
            assign chars_a[gi] = src_a[127 - 8*gi -: 8];
            assign chars_b[gi] = src_b[127 - 8*gi -: 8];
        end
    endgenerate

    // Position of the item that follows the current one.
    always_comb begin
        adv_seq  = seq_q;
        adv_step = step_q;
        adv_char = char_q;
        unique case (seq_q)
            S_PWRUP: begin
                adv_seq  = S_INIT_NIB;
                adv_step = 4'd0;
            end
            S_INIT_NIB: begin
                adv_step = step_q + 4'd1;
                if (step_q == 4'd3) adv_seq = S_INIT_CMD;
            end
            S_INIT_CMD: begin
                adv_step = step_q + 4'd1;
                if (step_q == 4'd7) adv_seq = S_ADDR_A;
            end
            S_ADDR_A: begin
                adv_seq  = S_CHARS_A;
                adv_char = 4'd0;
            end
            S_CHARS_A: begin
                adv_char = char_q + 4'd1;
                if (char_q == 4'd15) adv_seq = S_ADDR_B;
            end
            S_ADDR_B: begin
                adv_seq  = S_CHARS_B;
                adv_char = 4'd0;
            end
            S_CHARS_B: begin
                adv_char = char_q + 4'd1;
                if (char_q == 4'd15) adv_seq = S_ADDR_A;
            end
            default: adv_seq = S_PWRUP;
        endcase
    end

    // Content of that next item; init nibbles travel in the high half of the byte.
    always_comb begin
        item_byte = 8'h00;
        item_rs   = 1'b0;
        unique case (adv_seq)
            S_INIT_NIB: item_byte = (adv_step == 4'd3) ? 8'h20 : 8'h30;
            S_INIT_CMD: begin
                unique case (adv_step)
                    4'd4:    item_byte = 8'h28;
                    4'd5:    item_byte = 8'h0C;
                    4'd6:    item_byte = 8'h06;
                    default: item_byte = 8'h01;
                endcase
            end
            S_ADDR_A:  item_byte = 8'h80;
            S_ADDR_B:  item_byte = 8'hC0;
            S_CHARS_A: begin
                item_byte = chars_a[adv_char];
                item_rs   = 1'b1;
            end
            S_CHARS_B: begin
                item_byte = chars_b[adv_char];
                item_rs   = 1'b1;
            end
            default: item_byte = 8'h00;
        endcase
    end

    always_comb begin
        if (seq_q == S_INIT_NIB && step_q == 4'd0)
            wait_last = IWAIT_LAST;
        else if (seq_q == S_INIT_CMD && byte_q == 8'h01)
            wait_last = CLEAR_LAST;
        else
            wait_last = CMD_LAST;
    end

    always_comb begin
        seq_d        = seq_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q + 1'b1;
        step_d       = step_q;
        char_d       = char_q;
        byte_d       = byte_q;
        rs_d         = rs_q;
        nib_lo_d     = nib_lo_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        load         = 1'b0;
        if (seq_q == S_PWRUP) begin
            if (cnt_q == PWRUP_LAST) load = 1'b1;
        end else begin
            unique case (phase_q)
                P_SETUP: if (cnt_q == SETUP_LAST) begin
                    phase_d = P_EHI;
                    cnt_d   = '0;
                end
                P_EHI: if (cnt_q == E_LAST) begin
                    phase_d = P_EHOLD;
                    cnt_d   = '0;
                end
                P_EHOLD: if (cnt_q == E_LAST) begin
                    cnt_d = '0;
                    if (seq_q == S_INIT_NIB || nib_lo_q) begin
                        phase_d = P_WAIT;
                    end else begin
                        phase_d  = P_SETUP;
                        nib_lo_d = 1'b1;
                    end
                end
                P_WAIT: if (cnt_q == wait_last) load = 1'b1;
                default: phase_d = P_SETUP;
            endcase
        end
        if (load) begin
            seq_d    = adv_seq;
            step_d   = adv_step;
            char_d   = adv_char;
            byte_d   = item_byte;
            rs_d     = item_rs;
            nib_lo_d = 1'b0;
            phase_d  = P_SETUP;
            cnt_d    = '0;
            if (seq_q == S_INIT_CMD && adv_seq == S_ADDR_A) init_done_d = 1'b1;
            if (seq_q == S_CHARS_B && adv_seq == S_ADDR_A) frame_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q        <= S_PWRUP;
            phase_q      <= P_SETUP;
            cnt_q        <= '0;
            step_q       <= '0;
            char_q       <= '0;
            byte_q       <= '0;
            rs_q         <= 1'b0;
            nib_lo_q     <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            seq_q        <= seq_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            char_q       <= char_d;
            byte_q       <= byte_d;
            rs_q         <= rs_d;
            nib_lo_q     <= nib_lo_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign LCD_E      = (seq_q != S_PWRUP) && (phase_q == P_EHI);
    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_D      = nib_lo_q ? byte_q[3:0] : byte_q[7:4];
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_lcd_4bit_driver.sv
// Bench for lcd_4bit_driver: a frame-level text model fills a nibble scoreboard, a bus monitor
// decodes every E strobe and checks it together with strobe timing and the init/frame markers.
`timescale 1ns/1ps
module tb_lcd_4bit_driver;
    localparam int PW  = 50;
    localparam int IW  = 20;
    localparam int CW  = 8;
    localparam int CLW = 30;
    localparam int SU  = 2;
    localparam int EP  = 3;
    localparam int BYTE_CYC  = 2 * (SU + 2 * EP) + CW;
    localparam int FRAME_CYC = 34 * BYTE_CYC;
    localparam int NFRAMES   = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] row_A = '0;
    logic [127:0] row_B = '0;
    logic         LCD_E, LCD_RS, LCD_RW, init_done, frame_done;
    logic [3:0]   LCD_D;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [4:0] exp_q[$];

    lcd_4bit_driver #(
        .PWRUP_CYC(PW), .INIT_WAIT_CYC(IW), .CMD_WAIT_CYC(CW),
        .CLEAR_WAIT_CYC(CLW), .SETUP_CYC(SU), .E_PULSE_CYC(EP)
    ) dut (
        .clk(clk), .reset(reset), .row_A(row_A), .row_B(row_B),
        .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_D(LCD_D),
        .init_done(init_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [127:0] str_row(input string s);
        logic [127:0] r = '0;
        for (int k = 0; k < 16; k++) r = {r[119:0], s[k]};
        return r;
    endfunction

    function automatic logic [127:0] rand_row();
        logic [127:0] r = '0;
        for (int k = 0; k < 16; k++) r = {r[119:0], 8'($urandom_range(32, 126))};
        return r;
    endfunction

    function automatic logic [7:0] char_of(input logic [127:0] row, input int k);
        return 8'(row >> (8 * (15 - k)));
    endfunction

    task automatic push_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b[7:4]});
        exp_q.push_back({rs, b[3:0]});
    endtask

    task automatic push_init();
        logic [3:0] nibs [4];
        logic [7:0] cmds [4];
        nibs = '{4'h3, 4'h3, 4'h3, 4'h2};
        cmds = '{8'h28, 8'h0C, 8'h06, 8'h01};
        foreach (nibs[i]) exp_q.push_back({1'b0, nibs[i]});
        foreach (cmds[i]) push_byte(1'b0, cmds[i]);
    endtask

    // Row text changes at char m of the top row (m<0: no change during this frame).
    task automatic push_frame(input logic [127:0] old_a, input logic [127:0] new_a,
                              input logic [127:0] old_b, input logic [127:0] new_b, input int m);
        push_byte(1'b0, 8'h80);
        for (int k = 0; k < 16; k++) begin
`ifdef LCD_FRAME_LATCH_EN
            push_byte(1'b1, char_of(old_a, k));
`else
            push_byte(1'b1, char_of((k >= m) ? new_a : old_a, k));
`endif
        end
        push_byte(1'b0, 8'hC0);
        for (int k = 0; k < 16; k++) begin
`ifdef LCD_FRAME_LATCH_EN
            push_byte(1'b1, char_of(old_b, k));
`else
            push_byte(1'b1, char_of(new_b, k));
`endif
        end
    endtask

    // ---------------- bus monitor ----------------
    logic       prev_e = 1'b0, prev_init = 1'b0, prev_fd = 1'b0;
    logic [4:0] cur, cap, expn;
    logic [4:0] hist0 = '0, hist1 = '0;
    int         high_cnt = 0, hold = 0, last_fall = -1, last_fd = -1;

    always @(negedge clk) begin
        cyc++;
        cur = {LCD_RS, LCD_D};
        if (reset) begin
            prev_e    = LCD_E;
            prev_init = 1'b0;
            prev_fd   = 1'b0;
            hold      = 0;
            high_cnt  = 0;
            last_fall = -1;
            last_fd   = -1;
        end else begin
            check("rw_low", int'(LCD_RW), 0);
            if (LCD_E && !prev_e) begin
                check("setup_stable", int'({hist1, hist0}), int'({cur, cur}));
                cap      = cur;
                high_cnt = 0;
            end
            if (LCD_E) begin
                high_cnt++;
                check("ehi_stable", int'(cur), int'(cap));
            end
            if (!LCD_E && prev_e) begin
                check("e_width", high_cnt, EP);
                hold      = EP;
                last_fall = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL nibble: got rs=%0d d=%h required none (queue empty)", cap[4], cap[3:0]);
                end else begin
                    expn = exp_q.pop_front();
                    $display("nibble rs=%0d d=%h expected rs=%0d d=%h", cap[4], cap[3:0], expn[4], expn[3:0]);
                    check("nibble", int'(cap), int'(expn));
                end
            end
            if (hold > 0) begin
                check("ehold_stable", int'(cur), int'(cap));
                hold--;
            end
            if (prev_init) check("init_done_sticky", int'(init_done), 1);
            if (init_done && !prev_init) begin
                check("clear_gap", cyc - last_fall, EP + CLW);
                last_fd = cyc;
            end
            if (frame_done) begin
                check("fd_width", int'(prev_fd), 0);
                if (last_fd >= 0) check("frame_period", cyc - last_fd, FRAME_CYC);
                last_fd = cyc;
            end
            prev_e    = LCD_E;
            prev_init = init_done;
            prev_fd   = frame_done;
        end
        hist1 = hist0;
        hist0 = cur;
    end

    // ---------------- stimulus ----------------
    task automatic run_init();
        int n = 0;
        push_init();
        reset = 1'b0;
        while (!LCD_E && n < PW + SU + 20) begin
            @(negedge clk);
            n++;
        end
        check("first_e_rise", n, PW + SU);
        check("first_d", int'(LCD_D), 3);
        check("first_rs", int'(LCD_RS), 0);
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("init_done_timeout", int'(init_done), 1);
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < FRAME_CYC + 20);
        check("frame_done_timeout", int'(frame_done), 1);
    endtask

    logic [127:0] cur_a, cur_b, new_a, new_b;
    int m;
    int n;

    initial begin
        row_A = str_row("Fibo #00 is 0000");
        row_B = str_row("Fibo #01 is 0001");
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_e", int'(LCD_E), 0);
        check("rst_rs", int'(LCD_RS), 0);
        check("rst_rw", int'(LCD_RW), 0);
        check("rst_d", int'(LCD_D), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_frame_done", int'(frame_done), 0);
        run_init();
        cur_a = row_A;
        cur_b = row_B;
        wait_init();

        for (int f = 0; f <= NFRAMES; f++) begin
            m     = (f == 0 || f == NFRAMES) ? -1 : int'($urandom_range(0, 15));
            new_a = (m < 0) ? cur_a : rand_row();
            new_b = (m < 0) ? cur_b : rand_row();
            push_frame(cur_a, new_a, cur_b, new_b, m);
            $display("frame %0d: rows change at top-row char %0d", f, m);
            if (f == NFRAMES) break;
            if (m >= 0) begin
                repeat (BYTE_CYC * (1 + m) - 12) @(negedge clk);
                row_A = new_a;
                row_B = new_b;
            end
            cur_a = new_a;
            cur_b = new_b;
            wait_fd();
        end

        // Reset while E is high somewhere in the bottom-row characters.
        repeat (BYTE_CYC * 20) @(negedge clk);
        n = 0;
        while (!LCD_E && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("e_high_before_reset", int'(LCD_E), 1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_e_drop", int'(LCD_E), 0);
        check("reset_init_done", int'(init_done), 0);
        check("reset_d", int'(LCD_D), 0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        run_init();
        wait_init();
        push_frame(cur_a, cur_a, cur_b, cur_b, -1);
        $display("frame after reset: rows unchanged");
        wait_fd();
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
